// File: rtl/demux1a2_stream.sv
// Packet-level 1-to-2 stream demultiplexer with a one-entry registered buffer per output channel.
// Optional per-channel packet counters are enabled with the DEMUX_PKT_COUNT_EN macro.
module demux1a2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  input  logic             Din_last,
  output logic             Din_ready,
  input  logic             Sel,
  output logic [WIDTH-1:0] A,
  output logic             A_valid,
  output logic             A_last,
  input  logic             A_ready,
  output logic [WIDTH-1:0] B,
  output logic             B_valid,
  output logic             B_last,
  input  logic             B_ready,
  output logic             Busy,
  output logic             Cur_sel
`ifdef DEMUX_PKT_COUNT_EN
  ,
  output logic [15:0]      A_pkts,
  output logic [15:0]      B_pkts
`endif
);

  // Handshake: a beat moves on any rising edge where valid and ready are both 1;
  // ready never waits on valid, and a producer holds valid/data until accepted.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic target;
  logic can_load_a;
  logic can_load_b;
  logic xfer;
  logic load_a;
  logic load_b;

  assign can_load_a = !A_valid || A_ready;
  assign can_load_b = !B_valid || B_ready;
  assign xfer       = Din_valid && Din_ready;
  assign load_a     = xfer && !target;
  assign load_b     = xfer && target;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (xfer && !Din_last) state_nxt = Sel ? ROUTE_B : ROUTE_A;
      end
      ROUTE_A, ROUTE_B: begin
        if (xfer && Din_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sel only steers in IDLE; once a packet is open the route is taken from the state.
  always_comb begin
    target = Sel;
    case (state)
      ROUTE_A: target = 1'b0;
      ROUTE_B: target = 1'b1;
      default: target = Sel;
    endcase
    Din_ready = target ? can_load_b : can_load_a;
    Busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst)                      Cur_sel <= 1'b0;
    else if (xfer && state == IDLE) Cur_sel <= Sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A       <= '0;
      A_last  <= 1'b0;
      A_valid <= 1'b0;
    end else if (load_a) begin
      A       <= Din;
      A_last  <= Din_last;
      A_valid <= 1'b1;
    end else if (A_valid && A_ready) begin
      A_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      B       <= '0;
      B_last  <= 1'b0;
      B_valid <= 1'b0;
    end else if (load_b) begin
      B       <= Din;
      B_last  <= Din_last;
      B_valid <= 1'b1;
    end else if (B_valid && B_ready) begin
      B_valid <= 1'b0;
    end
  end

`ifdef DEMUX_PKT_COUNT_EN
  // Counted when the last beat leaves the channel, so it tracks delivered packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      A_pkts <= 16'd0;
      B_pkts <= 16'd0;
    end else begin
      if (A_valid && A_ready && A_last) A_pkts <= A_pkts + 16'd1;
      if (B_valid && B_ready && B_last) B_pkts <= B_pkts + 16'd1;
    end
  end
`endif

endmodule
